// File: rtl/pe_pkg.sv
// Shared constants, FSM state type and width sanity check for the
// 16-column dot-product tile accumulator.
package pe_pkg;

   localparam int DATA_W = 16;
   localparam int LANES  = 16;
   localparam int NTILES = 49;
   localparam int ACC_W  = 42;

   // Width of one column's adder-tree output before extension to ACC_W.
   localparam int SUM_W  = 2*DATA_W + $clog2(LANES);
   localparam int TCNT_W = (NTILES > 1) ? $clog2(NTILES) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   function automatic bit acc_w_ok();
      return ACC_W >= 2*DATA_W + $clog2(LANES*NTILES);
   endfunction

endpackage

// File: rtl/pe_dot_lane.sv
// One output column: LANES signed multipliers registered in P1, then an
// adder tree whose sum is registered in P2.
module pe_dot_lane
   import pe_pkg::*;
(
   input  logic                    clk,
   input  logic [LANES*DATA_W-1:0] i_vec,
   input  logic [LANES*DATA_W-1:0] i_col,
   output logic signed [SUM_W-1:0] o_sum
);

   logic signed [2*DATA_W-1:0] r_prod [LANES];
   logic signed [SUM_W-1:0]    w_tree;
   logic signed [SUM_W-1:0]    r_sum;

   // Operands are sign-extended to the product width so the multiply is
   // full precision without relying on context extension.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         r_prod[i] <= (2*DATA_W)'($signed(i_vec[(LANES-1-i)*DATA_W +: DATA_W]))
                    * (2*DATA_W)'($signed(i_col[(LANES-1-i)*DATA_W +: DATA_W]));
      end
   end

   always_comb begin
      w_tree = '0;
      for (int i = 0; i < LANES; i++) begin
         w_tree = w_tree + SUM_W'(r_prod[i]);
      end
   end

   always_ff @(posedge clk) begin
      r_sum <= w_tree;
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/pe_tile_mac.sv
// Accumulates LANES dot products over NTILES weight tiles and hands the
// full-precision results out with a valid/ready handshake.
module pe_tile_mac
   import pe_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*DATA_W-1:0]       vec,
   input  logic [LANES*LANES*DATA_W-1:0] cols,
   output logic [LANES*ACC_W-1:0]        res,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic [1:0]                    dbg_state,
   output logic [TCNT_W-1:0]             dbg_tcnt
);

   // Handshake: a beat transfers on a rising clk edge where in_valid and
   // in_ready are both high (likewise out_valid/out_ready for results);
   // ready never depends on the partner's valid.

   if (!acc_w_ok()) begin : g_acc_w_check
      $error("pe_tile_mac: ACC_W too narrow for LANES*NTILES accumulation");
   end

   state_t                  r_state;
   logic [TCNT_W-1:0]       r_tcnt;
   logic                    r_v1, r_f1, r_l1;
   logic                    r_v2, r_f2, r_l2;
   logic                    r_out_valid;
   logic signed [ACC_W-1:0] r_acc [LANES];
   logic signed [SUM_W-1:0] w_sum [LANES];
   logic                    w_accept;
   logic                    w_first;
   logic                    w_last;

   assign in_ready = !rst && (r_state == IDLE || r_state == ACC);
   assign w_accept = in_valid && in_ready;
   assign w_first  = (r_tcnt == '0);
   assign w_last   = (r_tcnt == TCNT_W'(NTILES-1));

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      pe_dot_lane u_lane (
         .clk   (clk),
         .i_vec (vec),
         .i_col (cols[(LANES-1-j)*LANES*DATA_W +: LANES*DATA_W]),
         .o_sum (w_sum[j])
      );
      assign res[(LANES-1-j)*ACC_W +: ACC_W] = r_acc[j];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_tcnt      <= '0;
         r_v1        <= 1'b0;
         r_f1        <= 1'b0;
         r_l1        <= 1'b0;
         r_v2        <= 1'b0;
         r_f2        <= 1'b0;
         r_l2        <= 1'b0;
         r_out_valid <= 1'b0;
         for (int j = 0; j < LANES; j++) r_acc[j] <= '0;
      end else begin
         // Tile flags ride alongside the lane pipeline so P3 knows when
         // to load versus add, independent of input bubbles.
         r_v1 <= w_accept;
         r_f1 <= w_first;
         r_l1 <= w_last;
         r_v2 <= r_v1;
         r_f2 <= r_f1;
         r_l2 <= r_l1;

         if (w_accept) r_tcnt <= w_last ? '0 : r_tcnt + 1'b1;

         if (r_v2) begin
            for (int j = 0; j < LANES; j++) begin
               r_acc[j] <= r_f2 ? ACC_W'(w_sum[j]) : r_acc[j] + ACC_W'(w_sum[j]);
            end
         end

         case (r_state)
            IDLE:  if (w_accept) r_state <= w_last ? DRAIN : ACC;
            ACC:   if (w_accept && w_last) r_state <= DRAIN;
            DRAIN: if (r_v2 && r_l2) begin
                      r_state     <= OUT;
                      r_out_valid <= 1'b1;
                   end
            OUT:   if (out_ready) begin
                      r_state     <= IDLE;
                      r_out_valid <= 1'b0;
                   end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign busy      = (r_state != IDLE);
   assign dbg_state = r_state;
   assign dbg_tcnt  = r_tcnt;

endmodule
